// File: rtl/tc_fetch8x4.sv
// tc_fetch8x4: byte-serial instruction fetch from an 8-bit ROM with valid/ready output and jump redirect
module tc_fetch8x4 #(
    parameter int                ADDR_W        = 16,
    parameter int                INSTR_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter bit                LITTLE_ENDIAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        o_address,
    input  logic [7:0]               i_rom_data,
    output logic [8*INSTR_BYTES-1:0] o_instr,
    output logic [ADDR_W-1:0]        o_instr_pc,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready,
    input  logic                     i_jump,
    input  logic [ADDR_W-1:0]        i_jump_target
);
    localparam int IDX_W = INSTR_BYTES > 1 ? $clog2(INSTR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(INSTR_BYTES - 1);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t                   r_state, w_state;
    logic [ADDR_W-1:0]        r_fetch_ptr, w_fetch_ptr;
    logic [ADDR_W-1:0]        r_start_pc, w_start_pc;
    logic [ADDR_W-1:0]        r_instr_pc, w_instr_pc;
    logic [IDX_W-1:0]         r_byte_idx, w_byte_idx, w_lane;
    logic [8*INSTR_BYTES-1:0] r_instr, w_instr;
    logic                     r_valid, w_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_fetch_ptr <= RESET_PC;
            r_start_pc  <= RESET_PC;
            r_instr_pc  <= RESET_PC;
            r_byte_idx  <= '0;
            r_instr     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_fetch_ptr <= w_fetch_ptr;
            r_start_pc  <= w_start_pc;
            r_instr_pc  <= w_instr_pc;
            r_byte_idx  <= w_byte_idx;
            r_instr     <= w_instr;
            r_valid     <= w_valid;
        end
    end
    always_comb begin
        w_lane      = LITTLE_ENDIAN ? r_byte_idx : LAST - r_byte_idx;
        w_state     = r_state;
        w_fetch_ptr = r_fetch_ptr;
        w_start_pc  = r_start_pc;
        w_instr_pc  = r_instr_pc;
        w_byte_idx  = r_byte_idx;
        w_instr     = r_instr;
        w_valid     = r_valid;
        if (i_jump) begin
            w_state     = FETCH;
            w_fetch_ptr = i_jump_target;
            w_start_pc  = i_jump_target;
            w_byte_idx  = '0;
            w_valid     = 1'b0;
        end else if (r_state == FETCH) begin
            w_instr[8*w_lane +: 8] = i_rom_data;
            w_fetch_ptr            = r_fetch_ptr + 1'b1;
            w_byte_idx             = (r_byte_idx == LAST) ? '0 : r_byte_idx + 1'b1;
            if (r_byte_idx == LAST) begin
                w_instr_pc = r_start_pc;
                w_valid    = 1'b1;
                w_state    = HOLD;
            end
        end else if (i_instr_ready) begin
            w_valid    = 1'b0;
            w_start_pc = r_fetch_ptr;
            w_state    = FETCH;
        end
    end
    assign o_address     = r_fetch_ptr;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_valid;
endmodule
